// File: rtl/debounce_edge_detect.sv
// Debounce and edge-detect stage for an already-synchronized level: accepts a new
// level after STABLE_CYCLES identical samples, pulses RISE/FALL and counts accepts.
module debounce_edge_detect #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic        INIT_LEVEL    = 1'b0,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 DATA_IN,
    input  logic                 CLEAR,
    output logic                 LEVEL,
    output logic                 RISE,
    output logic                 FALL,
    output logic [CNT_WIDTH-1:0] EVENT_CNT
);

    localparam int unsigned      RUN_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    localparam state_t RESET_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

    state_t                state_q, state_nxt;
    logic [RUN_W-1:0]      run_q, run_nxt;
    logic                  level_q, level_nxt;
    logic                  rise_q, rise_nxt;
    logic                  fall_q, fall_nxt;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RESET_STATE;
            run_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            run_q   <= run_nxt;
            level_q <= level_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        run_nxt   = run_q;
        level_nxt = level_q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state_q)
            STABLE_LO: begin
                if (DATA_IN) begin
                    if (STABLE_CYCLES == 1) begin
                        level_nxt = 1'b1;
                        rise_nxt  = 1'b1;
                        run_nxt   = '0;
                        state_nxt = STABLE_HI;
                    end else begin
                        run_nxt   = RUN_ONE;
                        state_nxt = CHECK_HI;
                    end
                end
            end

            CHECK_HI: begin
                if (!DATA_IN) begin
                    // Abandoned run: the level never changed, so nothing to undo.
                    run_nxt   = '0;
                    state_nxt = STABLE_LO;
                end else if (run_q == RUN_LAST) begin
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                    run_nxt   = '0;
                    state_nxt = STABLE_HI;
                end else begin
                    run_nxt = run_q + RUN_ONE;
                end
            end

            STABLE_HI: begin
                if (!DATA_IN) begin
                    if (STABLE_CYCLES == 1) begin
                        level_nxt = 1'b0;
                        fall_nxt  = 1'b1;
                        run_nxt   = '0;
                        state_nxt = STABLE_LO;
                    end else begin
                        run_nxt   = RUN_ONE;
                        state_nxt = CHECK_LO;
                    end
                end
            end

            CHECK_LO: begin
                if (DATA_IN) begin
                    run_nxt   = '0;
                    state_nxt = STABLE_HI;
                end else if (run_q == RUN_LAST) begin
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                    run_nxt   = '0;
                    state_nxt = STABLE_LO;
                end else begin
                    run_nxt = run_q + RUN_ONE;
                end
            end

            default: begin
                run_nxt   = '0;
                level_nxt = INIT_LEVEL;
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // A clear that coincides with an accept still records that accept.
    always_comb begin
        cnt_nxt = cnt_q;
        if (rise_nxt || fall_nxt) begin
            cnt_nxt = CLEAR ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
        end else if (CLEAR) begin
            cnt_nxt = '0;
        end
    end

    assign LEVEL     = level_q;
    assign RISE      = rise_q;
    assign FALL      = fall_q;
    assign EVENT_CNT = cnt_q;

endmodule
